rgb_depth_pipe: RTL and testbench
=================================

// Module: rgb_depth_pipe
// PURPOSE
//  Pipelined, parametrised colour-depth converter between the vicii RGB outputs and a digital video encoder.
//  Replaces the combinational x*255/63 channel scaling with registered logic.
//  Delays hsync/vsync/de to match the data path latency.
//  Forces data to zero outside the active area.
//  Supports width expansion (exact scaling) and width reduction (truncation with optional 2x2 ordered dither).
// PARAMETERS
//  IN_W      6  input bits per channel (2..10)
//  OUT_W     8  output bits per channel (2..10)
//  CHANNELS  3  colour channels packed into rgb_i/rgb_o; channel 0 is in the LSBs
//  PIPE      2  latency in pix_ce strobes (>=2)
// PORTS
//  clk_dot4x  in   1                 dot4x clock
//  rst        in   1                 asynchronous, active-high reset
//  pix_ce     in   1                 pixel strobe, one clk_dot4x cycle per pixel
//  hsync_i    in   1                 horizontal sync
//  vsync_i    in   1                 vertical sync
//  de_i       in   1                 active video
//  rgb_i      in   CHANNELS*IN_W     pixel data
//  dither_en  in   1                 enables dither; used only when OUT_W<IN_W
//  hsync_o    out  1                 delayed hsync
//  vsync_o    out  1                 delayed vsync
//  de_o       out  1                 delayed de
//  rgb_o      out  CHANNELS*OUT_W    converted pixel data
// BEHAVIOUR
//  Reset
//   - Every output register, pipeline stage and parity bit clears to 0 asynchronously on rst=1.
//   - Assertion mid-frame discards in-flight pixels.
//   - After release, outputs stay 0 until PIPE strobes have propagated real input.
//  Advance
//   - All registers (pipeline and parity) update only on a clk_dot4x edge with pix_ce=1; otherwise they hold.
//   - The sample taken at strobe n appears on the outputs after strobe n+PIPE-1, i.e. PIPE strobes of latency.
//   - Sync and de travel through a delay line with the same depth as the data.
//  Expand (OUT_W>=IN_W)
//   - Per channel: out = floor(in*(2^OUT_W-1)/(2^IN_W-1)).
//   - This is exact over the full input range, not an approximation.
//   - Stage 1 registers the product (IN_W+OUT_W bits); stage 2 divides by the constant.
//   - When OUT_W==IN_W, out = in.
//  Reduce (OUT_W<IN_W), with S = IN_W-OUT_W
//   - b = BAYER[{yp^fp, xp^fp}], where BAYER = {0,2,3,1} for idx 00,01,10,11.
//   - d = (b<<S)>>2 when dither_en=1; d = 0 otherwise.
//   - out = min((in+d)>>S, 2^OUT_W-1).
//   - The sum is IN_W+1 bits wide, so saturation is required.
//  Parity tracking (all updated on pix_ce only, at the pipeline input)
//   - xp: toggles on each de_i=1 sample; cleared on de_i=0.
//   - yp: toggles on de_i 1->0.
//   - yp clear and fp toggle: both happen on vsync_i 0->1.
//   - If the vsync rise and the de fall occur in the same strobe, the yp clear wins.
//  Blanking
//   - rgb_o = 0 whenever de_o = 0, regardless of the input data.
//  Constraints
//   - Pure datapath: no backpressure and no handshake beyond pix_ce.
//   - Any parameter outside its legal range is a $error at elaboration.
// TESTING
//  T1 expand: IN_W=6, OUT_W=8, de=1, R/G/B = 63/32/1
//     -> 255/129/4, appearing exactly 2 strobes later.
//  T2 stall: pix_ce pattern 1,0,0,1,1 with incrementing pixels
//     -> outputs change only on strobe edges; order is preserved and no pixel is duplicated or dropped.
//  T3 blank/sync alignment: de low for 4 pixels containing data 0x3F, with hsync pulsing
//     -> rgb_o=0 for those 4 pixels; hsync_o/de_o equal hsync_i/de_i delayed by PIPE strobes.
//  T4 dither: IN_W=8, OUT_W=6, dither_en=1, in=0x02 over a 2x2 block in frame 0
//     -> row 0 gives 0,1; row 1 gives 1,0.
//     -> After the next vsync rise (fp=1), the pattern is inverted.
//     -> With dither_en=0, all four outputs are 0.
//  T5 saturation: IN_W=8, OUT_W=6, in=0xFF at idx with b=3
//     -> out=63, with no wrap to 0.
//  T6 reset mid-frame: assert rst while PIPE pixels are in flight
//     -> all outputs are 0 immediately.
//     -> After release, the first valid output appears PIPE strobes later, and xp/yp/fp restart at 0.

Source files
------------

// File: rtl/rgb_depth_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rgb_depth_pipe
// Description : Pipelined per-channel colour-depth converter with sync/de delay
//               line, active-area blanking and optional 2x2 ordered dither.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_depth_pipe #(
  parameter int IN_W     = 6,
  parameter int OUT_W    = 8,
  parameter int CHANNELS = 3,
  parameter int PIPE     = 2
) (
  input  logic                      clk_dot4x,
  input  logic                      rst,
  input  logic                      pix_ce,
  input  logic                      hsync_i,
  input  logic                      vsync_i,
  input  logic                      de_i,
  input  logic [CHANNELS*IN_W-1:0]  rgb_i,
  input  logic                      dither_en,
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic                      de_o,
  output logic [CHANNELS*OUT_W-1:0] rgb_o
);

  localparam int c_PW = IN_W + OUT_W;
  localparam int c_S  = (OUT_W < IN_W) ? (IN_W - OUT_W) : 0;

  if (IN_W < 2 || IN_W > 10 || OUT_W < 2 || OUT_W > 10 ||
      CHANNELS < 1 || PIPE < 2) begin : g_param_err
    $error("rgb_depth_pipe: parameter out of legal range");
  end

  logic [PIPE-1:0]           r_hs;
  logic [PIPE-1:0]           r_vs;
  logic [PIPE-1:0]           r_de;
  logic                      r_xp;
  logic                      r_yp;
  logic                      r_fp;
  logic                      w_vs_rise;
  logic                      w_de_fall;
  logic [1:0]                w_idx;
  logic [1:0]                w_bayer;
  logic [IN_W:0]             w_d;
  logic [CHANNELS*OUT_W-1:0] w_s2;
  logic [CHANNELS*OUT_W-1:0] r_dat [PIPE-1];

  // r_vs[0]/r_de[0] hold the previous strobe's inputs, so they double as edge history
  assign w_vs_rise = vsync_i & ~r_vs[0];
  assign w_de_fall = ~de_i & r_de[0];
  assign w_idx     = {r_yp ^ r_fp, r_xp ^ r_fp};

  always_comb begin
    w_bayer = 2'd1;
    case (w_idx)
      2'b00:   w_bayer = 2'd0;
      2'b01:   w_bayer = 2'd2;
      2'b10:   w_bayer = 2'd3;
      default: w_bayer = 2'd1;
    endcase
  end

  assign w_d = dither_en ? (({{(IN_W-1){1'b0}}, w_bayer} << c_S) >> 2) : '0;

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      r_hs <= '0;
      r_vs <= '0;
      r_de <= '0;
      r_xp <= 1'b0;
      r_yp <= 1'b0;
      r_fp <= 1'b0;
    end else if (pix_ce) begin
      r_hs <= {r_hs[PIPE-2:0], hsync_i};
      r_vs <= {r_vs[PIPE-2:0], vsync_i};
      r_de <= {r_de[PIPE-2:0], de_i};
      r_xp <= de_i ? ~r_xp : 1'b0;
      if (w_vs_rise) begin
        r_yp <= 1'b0;
        r_fp <= ~r_fp;
      end else if (w_de_fall) begin
        r_yp <= ~r_yp;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [IN_W-1:0] w_in;
    assign w_in = rgb_i[c*IN_W +: IN_W];

    if (OUT_W >= IN_W) begin : g_expand
      localparam logic [c_PW-1:0] c_OMAX = c_PW'((1 << OUT_W) - 1);
      localparam logic [c_PW-1:0] c_IMAX = c_PW'((1 << IN_W) - 1);
      logic [c_PW-1:0] r_prod;
      logic [c_PW-1:0] w_quot;
      logic            w_unused;

      always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
          r_prod <= '0;
        end else if (pix_ce) begin
          r_prod <= {{OUT_W{1'b0}}, w_in} * c_OMAX;
        end
      end

      // Quotient never exceeds 2^OUT_W-1, so the upper bits are always zero
      assign w_quot                    = r_prod / c_IMAX;
      assign w_s2[c*OUT_W +: OUT_W]    = w_quot[OUT_W-1:0];
      assign w_unused                  = ^{w_quot[c_PW-1:OUT_W], w_d};
    end else begin : g_reduce
      localparam logic [IN_W:0] c_OMAX = (IN_W+1)'((1 << OUT_W) - 1);
      logic [IN_W:0]    w_sum;
      logic [IN_W:0]    w_shr;
      logic [OUT_W-1:0] r_red;

      assign w_sum = {1'b0, w_in} + w_d;
      assign w_shr = w_sum >> c_S;

      always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
          r_red <= '0;
        end else if (pix_ce) begin
          r_red <= (w_shr > c_OMAX) ? c_OMAX[OUT_W-1:0] : w_shr[OUT_W-1:0];
        end
      end

      assign w_s2[c*OUT_W +: OUT_W] = r_red;
    end
  end

  // Blank at the first data stage; zeros then ride the delay line with their de
  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE-1; k++) begin
        r_dat[k] <= '0;
      end
    end else if (pix_ce) begin
      r_dat[0] <= r_de[0] ? w_s2 : '0;
      for (int k = 1; k < PIPE-1; k++) begin
        r_dat[k] <= r_dat[k-1];
      end
    end
  end

  assign hsync_o = r_hs[PIPE-1];
  assign vsync_o = r_vs[PIPE-1];
  assign de_o    = r_de[PIPE-1];
  assign rgb_o   = r_dat[PIPE-2];

endmodule
`default_nettype wire

// File: tb/tb_rgb_depth_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rgb_depth_pipe
// Description : Bench for rgb_depth_pipe: a 6->8 expander and an 8->6 dithering
//               reducer share stimulus and are checked against a pixel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_depth_pipe;

  localparam int PE = 2;
  localparam int PR = 3;
  localparam int S  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        hs;
  logic        vs;
  logic        de;
  logic        den;
  logic [17:0] in_e;
  logic [23:0] in_r;
  logic        hs_e, vs_e, de_e, hs_r, vs_r, de_r;
  logic [23:0] out_e;
  logic [17:0] out_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rgb_depth_pipe #(.IN_W(6), .OUT_W(8), .CHANNELS(3), .PIPE(PE)) u_exp (
    .clk_dot4x(clk), .rst(rst), .pix_ce(ce), .hsync_i(hs), .vsync_i(vs),
    .de_i(de), .rgb_i(in_e), .dither_en(den), .hsync_o(hs_e),
    .vsync_o(vs_e), .de_o(de_e), .rgb_o(out_e)
  );

  rgb_depth_pipe #(.IN_W(8), .OUT_W(6), .CHANNELS(3), .PIPE(PR)) u_red (
    .clk_dot4x(clk), .rst(rst), .pix_ce(ce), .hsync_i(hs), .vsync_i(vs),
    .de_i(de), .rgb_i(in_r), .dither_en(den), .hsync_o(hs_r),
    .vsync_o(vs_r), .de_o(de_r), .rgb_o(out_r)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
  } smp_t;

  smp_t qe[$];
  smp_t qr[$];
  smp_t cur_e;
  smp_t cur_r;
  int   xcnt, ycnt, fcnt;
  logic pde, pvs;
  int   bayer [4] = '{0, 2, 3, 1};
  logic [17:0] rec [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int expand(input int v);
    return (v * 255) / 63;
  endfunction

  function automatic int reduce(input int v, input int b, input logic en);
    int d;
    int o;
    d = en ? ((b << S) >> 2) : 0;
    o = (v + d) >> S;
    return (o > 63) ? 63 : o;
  endfunction

  function automatic logic [17:0] rep6(input int v);
    logic [5:0] t;
    t = 6'(v);
    return {t, t, t};
  endfunction

  task automatic model_reset();
    qe.delete();
    qr.delete();
    repeat (PE-1) qe.push_back('0);
    repeat (PR-1) qr.push_back('0);
    cur_e = '0;
    cur_r = '0;
    xcnt  = 0;
    ycnt  = 0;
    fcnt  = 0;
    pde   = 1'b0;
    pvs   = 1'b0;
  endtask

  task automatic model_strobe();
    smp_t se;
    smp_t sr;
    int   b;
    b = bayer[2*((ycnt + fcnt) % 2) + ((xcnt + fcnt) % 2)];
    se = '0;
    se.hs = hs;
    se.vs = vs;
    se.de = de;
    sr = se;
    if (de) begin
      for (int c = 0; c < 3; c++) begin
        se.rgb[c*8 +: 8] = 8'(expand(int'(in_e[c*6 +: 6])));
        sr.rgb[c*6 +: 6] = 6'(reduce(int'(in_r[c*8 +: 8]), b, den));
      end
    end
    if (vs && !pvs) begin
      ycnt = 0;
      fcnt = fcnt + 1;
    end else if (!de && pde) begin
      ycnt = ycnt + 1;
    end
    xcnt = de ? xcnt + 1 : 0;
    pde  = de;
    pvs  = vs;
    qe.push_back(se);
    qr.push_back(sr);
    cur_e = qe.pop_front();
    cur_r = qr.pop_front();
  endtask

  task automatic check_outputs();
    check("hs_e",  hs_e,  cur_e.hs);
    check("vs_e",  vs_e,  cur_e.vs);
    check("de_e",  de_e,  cur_e.de);
    check("rgb_e", out_e, cur_e.rgb);
    check("hs_r",  hs_r,  cur_r.hs);
    check("vs_r",  vs_r,  cur_r.vs);
    check("de_r",  de_r,  cur_r.de);
    check("rgb_r", out_r, cur_r.rgb[17:0]);
  endtask

  task automatic step(input logic c, input logic h, input logic v, input logic d,
                      input logic [17:0] pe_, input logic [23:0] pr_);
    ce   = c;
    hs   = h;
    vs   = v;
    de   = d;
    in_e = pe_;
    in_r = pr_;
    @(posedge clk);
    if (c) model_strobe();
    @(negedge clk);
    check_outputs();
  endtask

  // Two 2-pixel rows separated by one blank strobe; rec[] gets the reducer outputs
  task automatic block(input logic [7:0] v);
    int slot [8] = '{0, 1, -1, 2, 3, -1, -1, -1};
    for (int j = 0; j < 8; j++) begin
      logic dd;
      dd = (slot[j] >= 0);
      step(1'b1, 1'b0, 1'b0, dd, '0, dd ? {v, v, v} : 24'h0);
      if (j >= PR-1 && slot[j-(PR-1)] >= 0) rec[slot[j-(PR-1)]] = out_r;
    end
  endtask

  task automatic vsync_pulse();
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int pat [5] = '{1, 0, 0, 1, 1};
    rst  = 1'b1;
    ce   = 1'b0;
    hs   = 1'b0;
    vs   = 1'b0;
    de   = 1'b0;
    den  = 1'b0;
    in_e = '0;
    in_r = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // T1: expand latency and exact values
    step(1'b1, 1'b0, 1'b0, 1'b1, {6'd1, 6'd32, 6'd63}, 24'h010203);
    check("t1_not_yet", out_e, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, {6'd1, 6'd32, 6'd63}, 24'h010203);
    check("t1_rgb", out_e, 32'h0481FF);

    // T2: stalled strobes
    for (int i = 0; i < 15; i++) begin
      step(pat[i%5] != 0, 1'b0, 1'b0, 1'b1, 18'(i*3 + 1), 24'(i*5 + 7));
    end

    // T3: blanking and sync alignment
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i == 3 || i == 4), 1'b0, !(i >= 2 && i < 6), 18'h3FFFF, 24'hFFFFFF);
    end

    // T6: reset with pixels in flight
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 18'h2AAAA, 24'h808080);
    rst = 1'b1;
    ce  = 1'b0;
    #1;
    check("t6_rgb_e", out_e, 32'h0);
    check("t6_rgb_r", out_r, 32'h0);
    check("t6_de_e",  de_e,  32'h0);
    check("t6_de_r",  de_r,  32'h0);
    check("t6_hs_e",  hs_e,  32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // T4: dither in frame 0, frame 1, and with dither disabled
    den = 1'b1;
    block(8'h02);
    check("t4_f0_p0", rec[0], rep6(0));
    check("t4_f0_p1", rec[1], rep6(1));
    check("t4_f0_p2", rec[2], rep6(1));
    check("t4_f0_p3", rec[3], rep6(0));
    vsync_pulse();
    block(8'h01);
    check("t4_f1_p0", rec[0], rep6(0));
    check("t4_f1_p1", rec[1], rep6(1));
    check("t4_f1_p2", rec[2], rep6(0));
    check("t4_f1_p3", rec[3], rep6(0));
    den = 1'b0;
    block(8'h02);
    for (int i = 0; i < 4; i++) check("t4_nodither", rec[i], rep6(0));

    // T5: saturation
    den = 1'b1;
    block(8'hFF);
    for (int i = 0; i < 4; i++) check("t5_sat", rec[i], rep6(63));

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) den = ~den;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 7) != 0,
           18'($urandom), 24'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
